// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, mid-bit sampling, 8N1 frames, valid/ready output.
// Define UART_RX_PARITY_EN to expect an even-parity bit before the stop bit (8E1).
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_parity_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop,
    StBreak
  } state_e;

  logic [1:0]      sync_q;
  logic            s_rx;
  logic            s_rx_prev_q;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            cnt_last;
  logic            par_err;

`ifdef UART_RX_PARITY_EN
  logic            par_err_q, par_err_d;
  logic            parity_err_q, parity_err_d;
  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  assign s_rx     = sync_q[1];
  assign cnt_last = (cnt_q == CntLast);

  // Line idles high, so the synchronizer resets to 1 to avoid a false start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 2'b11;
      s_rx_prev_q <= 1'b1;
    end else begin
      sync_q      <= {sync_q[0], rx_in};
      s_rx_prev_q <= s_rx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_err_q    <= par_err_d;
      parity_err_q <= parity_err_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    // An accepted byte drops valid unless a new one loads below.
    rx_valid_d  = rx_valid_q && !rx_ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d    = par_err_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (s_rx_prev_q && !s_rx) begin
          state_d = StStart;
        end
      end

      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d = '0;
          if (!s_rx) begin
            state_d   = StData;
            bit_idx_d = 3'd0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StData: begin
        if (cnt_last) begin
          cnt_d     = '0;
          shift_d   = {s_rx, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_last) begin
          cnt_d     = '0;
          // Even parity: data bits plus parity bit must have an even number of ones.
          par_err_d = s_rx ^ (^shift_q);
          state_d   = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif

      StStop: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (s_rx) begin
            state_d = StIdle;
            if (rx_valid_q && !rx_ready) begin
              overrun_d = 1'b1;
            end else begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            parity_err_d = par_err;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StBreak: begin
        cnt_d = '0;
        if (s_rx) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = frame_err_q;
  assign rx_overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = parity_err_q;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule
